ppe_rr_sched: RTL
=================

// Module: ppe_rr_sched
// PURPOSE
//  Round-robin scheduler built around the pipelined programmable priority encoder (PPE).
//  - Accumulates per-requester pending bits.
//  - Drives the PPE with a stable snapshot of the pending bits plus the rotating pointer P_enc.
//  - Presents one grant at a time on a valid/ready port.
//  - On acceptance, advances the pointer to the PPE's o_value_inc. This gives fair rotation across W requesters.
// PARAMETERS
//  W        1024  number of requesters (PPE width)
//  LOG_W    10    index width, $clog2(W)
//  PPE_LAT  2     PPE pipeline latency, Req/P_enc -> o_value/valid (cycles, >=1)
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, asynchronous, active-high
//  req_in       in   W      per-cycle request pulses, ORed into pending
//  sched_en     in   1      1 = new scheduling rounds allowed
//  cfg_ptr_we   in   1      pointer load strobe
//  cfg_ptr      in   LOG_W  pointer load value
//  gnt_valid    out  1      grant available
//  gnt_idx      out  LOG_W  granted requester index
//  gnt_ready    in   1      consumer accepts grant
//  pending_any  out  1      |pending
//  busy         out  1      state != IDLE
//  rr_ptr       out  LOG_W  current round-robin pointer
// BEHAVIOUR
//  Reset (async) values: pending=0, rr_ptr=0, state=IDLE, gnt_valid=0, gnt_idx=0, busy=0.
//   Internal PPE drive registers are also 0.
//  PPE contract: returns the lowest set index >= P_enc; if none, wraps to the lowest set index overall.
//   valid=0 iff Req==0. o_value_inc = (o_value+1) mod W.
//  pending update, every cycle: pending <= (pending & ~clr_mask) | req_in.
//   clr_mask is the one-hot gnt_idx on an accept cycle, else 0.
//   If set and clear hit the same bit in one cycle, set wins.
//  FSM:
//   IDLE  : if sched_en && pending_any -> LAUNCH.
//   LAUNCH: ppe_req <= pending; ppe_ptr <= rr_ptr; wcnt <= PPE_LAT-1; -> WAIT.
//           ppe_req/ppe_ptr are held stable until the next LAUNCH.
//   WAIT  : while wcnt != 0, decrement. At 0, sample the PPE outputs:
//           valid=1 -> gnt_idx <= o_value, nxt_ptr <= o_value_inc, -> GRANT.
//           valid=0 -> IDLE.
//   GRANT : gnt_valid=1.
//           gnt_ready=1 -> clear pending[gnt_idx], rr_ptr <= nxt_ptr, -> IDLE.
//           Otherwise hold gnt_idx stable; req_in arrivals never alter a presented grant.
//  Latency: pending bit set -> gnt_valid = PPE_LAT+3 cycles minimum.
//   Steady-state rate: one grant per PPE_LAT+3 cycles with gnt_ready held 1.
//  Pointer load: cfg_ptr_we writes rr_ptr in any state.
//   It takes priority over the GRANT-accept update in the same cycle.
//   It does not affect an in-flight PPE lookup.
//  sched_en=0: no new LAUNCH; an in-flight WAIT/GRANT completes normally.
//  Wrap: rr_ptr advancing from index W-1 yields 0 through o_value_inc; no special case.
//  gnt_valid deasserts the cycle after acceptance (registered). No back-to-back grants.
//  Reset mid-operation: everything returns to reset values immediately.
//   The PPE shares rst, so stale pipeline valids are never sampled.
//   No grant is issued until pending is re-set after release.
// STRUCTURE
//  Shared package (ppe_pkg): the state enum {IDLE, LAUNCH, WAIT, GRANT} and the W/LOG_W defaults.
//   The PPE_LAT constant for the ppe_w1024_p core also goes there.
//  One sub-module: ppe_w1024_p.
//   Ports clk, rst, Req, P_enc, o_value, o_value_inc, valid.
//   Req=ppe_req, P_enc=ppe_ptr.
//  Everything else (pending register, FSM, wait counter, grant registers) is local.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0 asynchronously; busy=0; rr_ptr=0.
//  2 Ordered grants: req_in bits {0,3,5,8} for 1 cycle, gnt_ready=1.
//    -> grants 0,3,5,8 in order; rr_ptr 1,4,6,9; then pending_any=0, busy=0.
//  3 Wrap: cfg_ptr=9, pending {3,1023} -> grant 1023, rr_ptr=0; then grant 3, rr_ptr=4.
//  4 Backpressure: gnt_ready=0 for 5 cycles during grant 5; req_in bit 2 pulsed meanwhile.
//    -> gnt_idx stays 5, gnt_valid stays 1; after accept, next grant is 8, then 2 after wrap.
//  5 Set/clear collision: re-pulse bit 3 on its accept cycle with pending {3,7}.
//    -> next grant 7, then 3 again.
//  6 All ones, cfg_ptr=500 -> grants 500,501,502, each PPE_LAT+3 cycles apart.
//    Reset during WAIT -> no grant after release; pending=0.

Source files
------------

// File: rtl/ppe_pkg.sv
// Shared definitions for the round-robin scheduler and its programmable priority encoder core.
package ppe_pkg;

    localparam int PPE_W        = 1024;
    localparam int PPE_LOG_W    = 10;
    localparam int PPE_LAT_CORE = 2;

    // The encoder is split into groups: a per-group "any" reduction, then a search inside the winning group.
    localparam int PPE_GRP      = 32;
    localparam int PPE_GRP_W    = 5;
    localparam int PPE_NGRP     = PPE_W / PPE_GRP;
    localparam int PPE_NGRP_W   = PPE_LOG_W - PPE_GRP_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        GRANT  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/ppe_w1024_p.sv
// Pipelined programmable priority encoder: lowest set index >= P_enc, wrapping to the lowest set index overall.
// Req/P_enc presented in cycle t yield o_value that a consumer registers at the end of cycle t+PPE_LAT_CORE-1.
module ppe_w1024_p
    import ppe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PPE_W-1:0]     Req,
    input  logic [PPE_LOG_W-1:0] P_enc,
    output logic [PPE_LOG_W-1:0] o_value,
    output logic [PPE_LOG_W-1:0] o_value_inc,
    output logic                 valid
);

    logic [PPE_W-1:0]      thr_mask;
    logic [PPE_W-1:0]      masked_req;
    logic                  use_masked;
    logic [PPE_W-1:0]      sel_vec;
    logic [PPE_NGRP-1:0]   grp_any;

    logic [PPE_W-1:0]      sel_reg;
    logic [PPE_NGRP-1:0]   grp_any_reg;
    logic                  valid_reg;

    logic [PPE_NGRP_W-1:0] grp_idx;
    logic [PPE_GRP-1:0]    grp_bits;
    logic [PPE_GRP_W-1:0]  bit_idx;

    generate
        for (genvar gi = 0; gi < PPE_W; gi++) begin : g_thr
            assign thr_mask[gi] = (PPE_LOG_W'(gi) >= P_enc);
        end
    endgenerate

    assign masked_req = Req & thr_mask;
    assign use_masked = |masked_req;
    // Searching the unmasked vector when nothing sits at or above the pointer gives the wrap-around.
    assign sel_vec    = use_masked ? masked_req : Req;

    generate
        for (genvar gi = 0; gi < PPE_NGRP; gi++) begin : g_grp
            assign grp_any[gi] = |sel_vec[gi*PPE_GRP +: PPE_GRP];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg     <= '0;
            grp_any_reg <= '0;
            valid_reg   <= 1'b0;
        end else begin
            sel_reg     <= sel_vec;
            grp_any_reg <= grp_any;
            valid_reg   <= |Req;
        end
    end

    always_comb begin
        grp_idx = '0;
        for (int g = PPE_NGRP - 1; g >= 0; g--) begin
            if (grp_any_reg[g]) begin
                grp_idx = PPE_NGRP_W'(g);
            end
        end
    end

    assign grp_bits = sel_reg[{grp_idx, {PPE_GRP_W{1'b0}}} +: PPE_GRP];

    always_comb begin
        bit_idx = '0;
        for (int b = PPE_GRP - 1; b >= 0; b--) begin
            if (grp_bits[b]) begin
                bit_idx = PPE_GRP_W'(b);
            end
        end
    end

    assign o_value     = {grp_idx, bit_idx};
    assign o_value_inc = o_value + 1'b1;
    assign valid       = valid_reg;

endmodule

// File: rtl/ppe_rr_sched.sv
// Round-robin scheduler: accumulates pending requests, looks up the next one through the PPE,
// and presents one grant at a time on a valid/ready port, advancing the pointer on each accept.
module ppe_rr_sched
    import ppe_pkg::*;
#(
    parameter int W       = PPE_W,
    parameter int LOG_W   = PPE_LOG_W,
    parameter int PPE_LAT = PPE_LAT_CORE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     req_in,
    input  logic             sched_en,
    input  logic             cfg_ptr_we,
    input  logic [LOG_W-1:0] cfg_ptr,
    output logic             gnt_valid,
    output logic [LOG_W-1:0] gnt_idx,
    input  logic             gnt_ready,
    output logic             pending_any,
    output logic             busy,
    output logic [LOG_W-1:0] rr_ptr
);

    localparam int CNT_W = (PPE_LAT > 1) ? $clog2(PPE_LAT) : 1;

    sched_state_t     state_reg;
    sched_state_t     state_next;
    logic [CNT_W-1:0] wcnt_reg;
    logic [CNT_W-1:0] wcnt_next;

    logic [W-1:0]     pending_reg;
    logic [W-1:0]     clr_mask;
    logic [W-1:0]     ppe_req_reg;
    logic [LOG_W-1:0] ppe_ptr_reg;
    logic [LOG_W-1:0] gnt_idx_reg;
    logic [LOG_W-1:0] nxt_ptr_reg;
    logic [LOG_W-1:0] rr_ptr_reg;
    logic             gnt_valid_reg;

    logic             accept;
    logic             ppe_load;
    logic             grant_load;

    logic [LOG_W-1:0] ppe_value;
    logic [LOG_W-1:0] ppe_value_inc;
    logic             ppe_valid;

    ppe_w1024_p u_ppe (
        .clk         (clk),
        .rst         (rst),
        .Req         (ppe_req_reg),
        .P_enc       (ppe_ptr_reg),
        .o_value     (ppe_value),
        .o_value_inc (ppe_value_inc),
        .valid       (ppe_valid)
    );

    assign accept = (state_reg == GRANT) && gnt_ready;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_clr
            assign clr_mask[gi] = accept && (gnt_idx_reg == LOG_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        ppe_load   = 1'b0;
        grant_load = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sched_en && pending_any) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                ppe_load   = 1'b1;
                wcnt_next  = CNT_W'(PPE_LAT - 1);
                state_next = WAIT;
            end
            WAIT: begin
                if (wcnt_reg != '0) begin
                    wcnt_next = wcnt_reg - 1'b1;
                end else if (ppe_valid) begin
                    grant_load = 1'b1;
                    state_next = GRANT;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                if (gnt_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            wcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg   <= '0;
            ppe_req_reg   <= '0;
            ppe_ptr_reg   <= '0;
            gnt_idx_reg   <= '0;
            nxt_ptr_reg   <= '0;
            gnt_valid_reg <= 1'b0;
            rr_ptr_reg    <= '0;
        end else begin
            // OR-ing req_in after the clear lets a same-cycle re-request survive the accept.
            pending_reg   <= (pending_reg & ~clr_mask) | req_in;
            gnt_valid_reg <= (state_next == GRANT);
            if (ppe_load) begin
                ppe_req_reg <= pending_reg;
                ppe_ptr_reg <= rr_ptr_reg;
            end
            if (grant_load) begin
                gnt_idx_reg <= ppe_value;
                nxt_ptr_reg <= ppe_value_inc;
            end
            if (cfg_ptr_we) begin
                rr_ptr_reg <= cfg_ptr;
            end else if (accept) begin
                rr_ptr_reg <= nxt_ptr_reg;
            end
        end
    end

    assign pending_any = |pending_reg;
    assign busy        = (state_reg != IDLE);
    assign gnt_valid   = gnt_valid_reg;
    assign gnt_idx     = gnt_idx_reg;
    assign rr_ptr      = rr_ptr_reg;

endmodule
